// File: rtl/vga_pkg.sv
// VGA 640x480@60 Hz timing constants and coordinate type shared by the sync
// generator and the downstream pixel graphics generator.
package vga_pkg;

    localparam int COORD_W = 10;

    localparam int VGA_CLK_DIV   = 2;
    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;

    localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int VGA_H_SYNC_START = VGA_H_DISPLAY + VGA_H_FRONT;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
    localparam int VGA_V_SYNC_START = VGA_V_DISPLAY + VGA_V_FRONT;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

    typedef logic [COORD_W-1:0] coord_t;

    // Inclusive range test used for both sync pulse decodes
    function automatic logic in_window(input coord_t pos, input coord_t first, input coord_t last);
        return (pos >= first) && (pos <= last);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up counter with enable, a next-state view for look-ahead decoding,
// and a wrap strobe that fires on the enabled terminal count.
module mod_counter
    import vga_pkg::*;
#(
    parameter int MODULUS = 2,
    parameter int WIDTH   = COORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] next_s;

    // Advance on enable; any value at or past the terminal count (e.g. after an upset) folds to zero
    always_comb begin
        next_s = count_r;
        if (en) begin
            if (count_r >= TERM) begin
                next_s = {WIDTH{1'b0}};
            end else begin
                next_s = count_r + WIDTH'(1'b1);
            end
        end else begin
            next_s = count_r;
        end
    end

    // Count state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {WIDTH{1'b0}};
        end else begin
            count_r <= next_s;
        end
    end

    assign count      = count_r;
    assign count_next = next_s;
    assign wrap       = en && (count_r == TERM);

endmodule

// File: rtl/vga_sync.sv
// VGA raster timing generator: pixel-tick divider, horizontal/vertical scan
// counters and registered, glitch-free active-low sync outputs.
module vga_sync
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = VGA_CLK_DIV,
    parameter int H_DISPLAY = VGA_H_DISPLAY,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_DISPLAY = VGA_V_DISPLAY,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK
) (
    input  logic               clk,
    input  logic               reset,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               p_tick,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               frame_end
);

    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_FIRST = H_DISPLAY + H_FRONT;
    localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST = V_DISPLAY + V_FRONT;
    localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic             run_r;
    logic             hsync_r;
    logic             vsync_r;
    logic             p_tick_s;
    logic [DIV_W-1:0] div_cnt_unused_s;
    logic [DIV_W-1:0] div_next_unused_s;
    coord_t           h_count_s;
    coord_t           h_next_s;
    logic             h_wrap_s;
    coord_t           v_count_s;
    coord_t           v_next_s;
    logic             v_wrap_s;

    // The first edge after reset release only arms the divider, so scanning restarts cleanly at (0,0)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    mod_counter #(
        .MODULUS (CLK_DIV),
        .WIDTH   (DIV_W)
    ) u_div (
        .clk        (clk),
        .reset      (reset),
        .en         (run_r),
        .count      (div_cnt_unused_s),
        .count_next (div_next_unused_s),
        .wrap       (p_tick_s)
    );

    mod_counter #(
        .MODULUS (H_TOTAL),
        .WIDTH   (COORD_W)
    ) u_h_count (
        .clk        (clk),
        .reset      (reset),
        .en         (p_tick_s),
        .count      (h_count_s),
        .count_next (h_next_s),
        .wrap       (h_wrap_s)
    );

    mod_counter #(
        .MODULUS (V_TOTAL),
        .WIDTH   (COORD_W)
    ) u_v_count (
        .clk        (clk),
        .reset      (reset),
        .en         (h_wrap_s),
        .count      (v_count_s),
        .count_next (v_next_s),
        .wrap       (v_wrap_s)
    );

    // Sync pulses decoded from next-state counts so they change on the same edge as pixel_x/pixel_y
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync_r <= 1'b1;
            vsync_r <= 1'b1;
        end else begin
            hsync_r <= ~in_window(h_next_s, COORD_W'(HS_FIRST), COORD_W'(HS_LAST));
            vsync_r <= ~in_window(v_next_s, COORD_W'(VS_FIRST), COORD_W'(VS_LAST));
        end
    end

    assign hsync     = hsync_r;
    assign vsync     = vsync_r;
    assign p_tick    = p_tick_s;
    assign pixel_x   = h_count_s;
    assign pixel_y   = v_count_s;
    assign video_on  = (h_count_s < COORD_W'(H_DISPLAY)) && (v_count_s < COORD_W'(V_DISPLAY));
    assign frame_end = v_wrap_s;

endmodule

// File: tb/tb_vga_sync.sv
// Self-checking bench for vga_sync: default, CLK_DIV=1 and a shrunken geometry
// instance, all compared every clock against an arithmetic raster model.
module tb_vga_sync;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       von;
        logic       pt;
        logic       fe;
        logic [9:0] x;
        logic [9:0] y;
    } view_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   k     = 0;
    int   d_hs_low  = 0;
    int   o_hs_low  = 0;
    int   s_fe_seen = 0;

    always #10 clk = ~clk;

    logic d_hs, d_vs, d_von, d_pt, d_fe;
    logic [9:0] d_x, d_y;
    logic o_hs, o_vs, o_von, o_pt, o_fe;
    logic [9:0] o_x, o_y;
    logic s_hs, s_vs, s_von, s_pt, s_fe;
    logic [9:0] s_x, s_y;
    view_t d_view, o_view, s_view;

    assign d_view = {d_hs, d_vs, d_von, d_pt, d_fe, d_x, d_y};
    assign o_view = {o_hs, o_vs, o_von, o_pt, o_fe, o_x, o_y};
    assign s_view = {s_hs, s_vs, s_von, s_pt, s_fe, s_x, s_y};

    vga_sync u_def (
        .clk(clk), .reset(reset), .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
        .p_tick(d_pt), .pixel_x(d_x), .pixel_y(d_y), .frame_end(d_fe)
    );

    vga_sync #(.CLK_DIV(1)) u_div1 (
        .clk(clk), .reset(reset), .hsync(o_hs), .vsync(o_vs), .video_on(o_von),
        .p_tick(o_pt), .pixel_x(o_x), .pixel_y(o_y), .frame_end(o_fe)
    );

    vga_sync #(
        .CLK_DIV(3), .H_DISPLAY(10), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(3), .V_BACK(4)
    ) u_small (
        .clk(clk), .reset(reset), .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
        .p_tick(s_pt), .pixel_x(s_x), .pixel_y(s_y), .frame_end(s_fe)
    );

    // Raster position after kk clock edges since reset release: edge 1 arms, then one pixel per d clocks
    function automatic view_t model(input int kk, input int d,
                                    input int hd, input int hf, input int hsw, input int hb,
                                    input int vd, input int vf, input int vsw, input int vb);
        view_t e;
        int    ht, vt, p, h, v;
        logic  tick;
        ht = hd + hf + hsw + hb;
        vt = vd + vf + vsw + vb;
        if (kk == 0) begin
            p    = 0;
            tick = 1'b0;
        end else begin
            p    = (kk - 1) / d;
            tick = (((kk - 1) % d) == d - 1);
        end
        h = p % ht;
        v = (p / ht) % vt;
        e.hs  = !((h >= hd + hf) && (h <= hd + hf + hsw - 1));
        e.vs  = !((v >= vd + vf) && (v <= vd + vf + vsw - 1));
        e.von = (h < hd) && (v < vd);
        e.pt  = tick;
        e.fe  = tick && (h == ht - 1) && (v == vt - 1);
        e.x   = 10'(h);
        e.y   = 10'(v);
        return e;
    endfunction

    task automatic check_view(input string tag, input view_t obs, input view_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s k=%0d: got %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s k=%0d: got %0d expected %0d", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        check_view("def",   d_view, model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33));
        check_view("div1",  o_view, model(k, 1, 640, 16, 96, 48, 480, 10, 2, 33));
        check_view("small", s_view, model(k, 3, 10, 3, 4, 5, 6, 2, 3, 4));
    endtask

    // One clock: sample 1 ns after the edge, advance the model only while out of reset
    task automatic step();
        @(posedge clk);
        #1;
        if (!reset) begin
            k++;
            if (!d_hs) d_hs_low++;
            if (!o_hs) o_hs_low++;
            if (s_fe)  s_fe_seen++;
        end else begin
            k = 0;
        end
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        k = 0;
        check_all();
        check_val("reset video_on", int'(d_von), 1);
        check_val("reset p_tick",   int'(d_pt),  0);
        check_val("reset hsync",    int'(d_hs),  1);
        #4 reset = 1'b0;

        run(1);
        check_val("p_tick after 1 edge", int'(d_pt), 0);
        run(1);
        check_val("p_tick after 2 edges", int'(d_pt), 1);
        check_val("div1 p_tick running", int'(o_pt), 1);
        run(1);
        check_val("pixel_x after 3 edges", int'(d_x), 1);

        run(987);
        check_val("small frame_end", int'(s_fe), 1);
        check_val("small last x", int'(s_x), 21);
        check_val("small last y", int'(s_y), 14);
        run(1);
        check_val("small wrap x", int'(s_x), 0);
        check_val("small wrap y", int'(s_y), 0);
        check_val("small wrap video_on", int'(s_von), 1);

        run(610);
        check_val("def line wrap x", int'(d_x), 0);
        check_val("def line wrap y", int'(d_y), 1);
        check_val("def hsync low clks", d_hs_low, 192);
        check_val("div1 two lines y", int'(o_y), 2);
        check_val("div1 hsync low clks", o_hs_low, 192);
        check_val("small frame_end pulses", s_fe_seen, 1);

        // Random free-run lengths with asynchronous resets landing between clock edges
        for (int it = 0; it < 5; it++) begin
            run(int'($urandom_range(300, 2500)));
            @(posedge clk);
            #(int'($urandom_range(2, 8)));
            reset = 1'b1;
            #1;
            k = 0;
            check_all();
            check_val("async clear pixel_x", int'(d_x), 0);
            run(int'($urandom_range(1, 3)));
            #(int'($urandom_range(3, 8)));
            reset = 1'b0;
        end
        run(1700);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_sync.md
Name: vga_sync

Overview:
- Generates VGA 640x480@60 Hz timing from the 50 MHz board clock.
- Sits directly upstream of the pixel graphics generator. It supplies that generator's video_on, pix_x and pix_y inputs, and drives the hsync/vsync pins.
- Contains a pixel-tick divider and horizontal/vertical scan counters. Sync outputs are registered and glitch-free.

Parameters:
- CLK_DIV, 2, clk cycles per pixel (50 MHz -> 25 MHz pixel rate); legal range >= 1.
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync pulse width (pixels).
- H_BACK, 48, horizontal back porch (pixels).
- V_DISPLAY, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_BACK, 33, vertical back porch (lines).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- hsync  out  1  horizontal sync, active low, registered.
- vsync  out  1  vertical sync, active low, registered.
- video_on  out  1  high while the current pixel is inside the visible area.
- p_tick  out  1  one-clk pulse, once every CLK_DIV clks; marks a pixel advance.
- pixel_x  out  10  current horizontal count, 0..H_TOTAL-1.
- pixel_y  out  10  current vertical count, 0..V_TOTAL-1.
- frame_end  out  1  one-clk pulse on the last pixel of a frame.

Behaviour:
- Derived constants:
  - H_TOTAL = sum of the four H_* parameters = 800.
  - V_TOTAL = sum of the four V_* parameters = 525.
  - Both totals must be <= 1024.
- Reset (async, active-high):
  - div_cnt=0, h_count=0, v_count=0.
  - hsync=1, vsync=1.
  - Consequently p_tick=0 (when CLK_DIV>1), video_on=1, frame_end=0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps to 0.
  - p_tick = (div_cnt == CLK_DIV-1), combinational.
  - With CLK_DIV=1, p_tick is constantly 1 outside reset.
- Horizontal counter:
  - Updates only on clk edges where p_tick=1.
  - Increments, wrapping H_TOTAL-1 -> 0.
- Vertical counter:
  - Increments only on clk edges where p_tick=1 and h_count = H_TOTAL-1.
  - Wraps V_TOTAL-1 -> 0 on the same edge that h_count wraps.
- Sync outputs:
  - Registered and decoded from the next-state counter values, so they stay aligned with pixel_x/pixel_y in the same cycle.
  - hsync = 0 iff H_DISPLAY+H_FRONT <= h_count <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
  - vsync = 0 iff V_DISPLAY+V_FRONT <= v_count <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491).
- video_on = (h_count < H_DISPLAY) && (v_count < V_DISPLAY), combinational from registered counters.
- pixel_x and pixel_y are driven directly from h_count and v_count.
- frame_end = p_tick && h_count==H_TOTAL-1 && v_count==V_TOTAL-1.
- Line period = H_TOTAL*CLK_DIV clks = 1600.
- Frame period = H_TOTAL*V_TOTAL*CLK_DIV = 840000 clks.
- Reset asserted mid-frame: all registers clear immediately, without waiting for a clock. Scanning restarts at (0,0) on the first clk edge after deassertion; the first p_tick occurs CLK_DIV clk edges after deassertion.
- No illegal states: counters never exceed their totals. Any out-of-range value (e.g. from SEU) wraps to 0 on the next advance.

Decomposition:
- Shared package vga_pkg holds:
  - the timing constants (H_*, V_*, H_TOTAL, V_TOTAL);
  - derived sync start/end positions;
  - the 10-bit coordinate width, also used by the graphics generator.
- One natural sub-module, mod_counter: parameterised modulus, enable input, wrap output.
  - Instantiated three times: divider, h_count, v_count.
  - h_count's wrap output gates v_count's enable.

Test Plan:
- Reset asserted mid-scan, asynchronous (between clk edges) -> outputs clear immediately: pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=1, p_tick=0. After release, p_tick first rises 2 clk edges later and pixel_x=1 after the next edge.
- Free run one line -> p_tick high every 2nd clk. pixel_x counts 0..799 then returns to 0 after 1600 clks, and pixel_y increments 0->1 on that wrap.
- Horizontal decode -> video_on falls when pixel_x goes 639->640. hsync falls at pixel_x=656, rises at pixel_x=752, low for exactly 96 p_ticks (192 clks).
- Vertical decode -> vsync low exactly while pixel_y is 490..491 (2 lines = 3200 clks). video_on stays 0 for all of pixel_y 480..524.
- Full frame -> frame_end pulses once per 840000 clks, for 1 clk, at (799,524). The next cycle's counters read (0,0) with video_on=1.
- CLK_DIV=1 build -> p_tick constantly 1; line period 800 clks; hsync low from pixel_x 656 to 751.
